led_breather: RTL and testbench

Downstream consumer of the divided slow clock (`CLK_100HZ`) in the lab LED/PMOD design. The block re-times that slow square wave into the `CLK100MHZ` domain and turns each rising edge into a one-cycle step pulse. Those pulses drive a brightness state machine with three patterns: steady, blink and breathe. A glitch-free PWM output at `CLK100MHZ` rate then drives an LED or PMOD pin, so the slow clock sets the pattern speed rather than lighting the LED directly.

---
 rtl/led_breather_pkg.sv | 37 +++
 rtl/tick_sync_edge.sv | 31 +++
 rtl/led_breather.sv | 114 +++++++++++
 tb/tb_led_breather.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_breather_pkg.sv
// Shared types and constants for the LED breather slice.
// Imported by the synchronizer and the top-level pattern engine.
package led_breather_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEADY,
    ST_BLINK,
    ST_RAMP_UP,
    ST_RAMP_DOWN
  } state_t;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STEADY  = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  localparam int SYNC_DEPTH = 2;

  function automatic state_t entry_state(
    input logic       en,
    input logic [1:0] md
  );
    state_t s;
    s = ST_IDLE;
    if (en) begin
      case (md)
        MODE_STEADY:  s = ST_STEADY;
        MODE_BREATHE: s = ST_RAMP_UP;
        MODE_BLINK:   s = ST_BLINK;
        default:      s = ST_IDLE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes an asynchronous level and emits a one-cycle
// pulse per rising edge; also suits the button inputs.
module tick_sync_edge
  import led_breather_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_last;
  logic                  r_pulse;

  // Pulse is registered so downstream sees a clean flop output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_last  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_DEPTH-2:0], i_async};
      r_last  <= r_sync[SYNC_DEPTH-1];
      r_pulse <= r_sync[SYNC_DEPTH-1] & ~r_last;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/led_breather.sv
// Slow-tick driven brightness pattern engine with a
// period-boundary latched PWM output.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_TICKS = 1
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  input  logic                tick_in,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                tick_pulse
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int CTR_W =
    (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST =
    CTR_W'(STEP_TICKS - 1);

  logic                w_pulse;
  logic [2:0]          w_cfg;
  logic                w_cfg_chg;
  logic                w_wrap;
  logic                w_step;
  state_t              w_entry;

  logic [2:0]          r_cfg;
  state_t              r_state;
  logic [CTR_W-1:0]    r_step_ctr;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_pwm_ctr;
  logic [PWM_BITS-1:0] r_level_sh;
  logic                r_pwm;

  tick_sync_edge u_sync (
    .i_clk   (CLK100MHZ),
    .i_rst   (RST),
    .i_async (tick_in),
    .o_pulse (w_pulse)
  );

  assign w_cfg     = {enable, mode};
  assign w_cfg_chg = (w_cfg != r_cfg);
  assign w_wrap    = (r_step_ctr == CTR_LAST);
  assign w_step    = w_pulse & w_wrap;
  assign w_entry   = entry_state(enable, mode);

  // A config change re-enters its pattern and eats any step.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_cfg      <= '0;
      r_state    <= ST_IDLE;
      r_step_ctr <= '0;
      r_level    <= '0;
    end else begin
      r_cfg <= w_cfg;
      if (w_cfg_chg) begin
        r_state    <= w_entry;
        r_step_ctr <= '0;
        r_level    <= (w_entry == ST_STEADY) ? MAX : '0;
      end else begin
        if (w_pulse)
          r_step_ctr <= w_wrap ? '0 : r_step_ctr + 1'b1;
        if (w_step) begin
          case (r_state)
            ST_BLINK: begin
              r_level <= (r_level == '0) ? MAX : '0;
            end
            ST_RAMP_UP: begin
              r_level <= r_level + 1'b1;
              if (r_level == MAX - 1'b1)
                r_state <= ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
              r_level <= r_level - 1'b1;
              if (r_level == PWM_BITS'(1))
                r_state <= ST_RAMP_UP;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Shadow level only moves at the period end, so no glitches.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_pwm_ctr  <= '0;
      r_level_sh <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_pwm_ctr <= r_pwm_ctr + 1'b1;
      if (r_state == ST_IDLE) begin
        r_level_sh <= '0;
        r_pwm      <= 1'b0;
      end else begin
        if (r_pwm_ctr == MAX)
          r_level_sh <= r_level;
        r_pwm <= (r_pwm_ctr < r_level_sh);
      end
    end
  end

  assign pwm_out    = r_pwm;
  assign level      = r_level;
  assign tick_pulse = w_pulse;

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather (STEP_TICKS=3):
// stimulus queues expected pulses/levels, a monitor checks them.
module tb_led_breather;

  typedef struct {
    int lvl;
    int cyc;
  } lexp_t;

  logic       clk;
  logic       RST;
  logic       tick_in;
  logic       enable;
  logic [1:0] mode;
  logic       pwm_out;
  logic [7:0] level;
  logic       tick_pulse;

  int    cyc  = 0;
  int    nchk = 0;
  int    nerr = 0;
  lexp_t lvl_q[$];
  int    pulse_q[$];

  led_breather #(
    .PWM_BITS   (8),
    .STEP_TICKS (3)
  ) u_dut (
    .CLK100MHZ  (clk),
    .RST        (RST),
    .tick_in    (tick_in),
    .enable     (enable),
    .mode       (mode),
    .pwm_out    (pwm_out),
    .level      (level),
    .tick_pulse (tick_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_lvl(input int lvl, input int at);
    lexp_t e;
    e.lvl = lvl;
    e.cyc = at;
    lvl_q.push_back(e);
  endtask

  // Monitor: pops on every pulse and every level change.
  initial begin
    logic [7:0] last;
    lexp_t      e;
    int         pe;
    last = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_pulse === 1'b1) begin
        if (pulse_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL pulse_unexpected: pulse at cycle %0d, required none",
                   cyc);
        end else begin
          pe = pulse_q.pop_front();
          chk("pulse_cyc", cyc, pe);
        end
      end
      if (level !== last) begin
        if (lvl_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL level_unexpected: level %0d at cycle %0d, required %0d",
                   level, cyc, last);
        end else begin
          e = lvl_q.pop_front();
          chk("level_val", int'(level), e.lvl);
          chk("level_cyc", cyc, e.cyc);
        end
        last = level;
      end
    end
  end

  task automatic tick(input bit stp, input int lvl);
    int n;
    @(negedge clk);
    tick_in = 1'b1;
    n = cyc;
    pulse_q.push_back(n + 3);
    if (stp) push_lvl(lvl, n + 4);
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic step3(input int lvl);
    tick(1'b0, 0);
    tick(1'b0, 0);
    tick(1'b1, lvl);
  endtask

  task automatic set_cfg(input bit en, input logic [1:0] md,
                         input bit chg, input int lvl);
    @(negedge clk);
    enable = en;
    mode   = md;
    if (chg) push_lvl(lvl, cyc + 1);
  endtask

  task automatic duty(input string nm, input int exp);
    int cnt;
    repeat (520) @(posedge clk);
    #1;
    cnt = 0;
    repeat (256) begin
      @(posedge clk);
      #1;
      if (pwm_out === 1'b1) cnt++;
    end
    chk(nm, cnt, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  k;
    bit  got;
    int  lv;
    RST     = 1'b1;
    enable  = 1'b1;
    mode    = 2'b10;
    tick_in = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_pulse", int'(tick_pulse), 0);
      @(negedge clk);
      tick_in = ~tick_in;
    end
    @(negedge clk);
    tick_in = 1'b0;
    RST     = 1'b0;

    step3(1);
    duty("duty_l1", 1);

    for (int s = 2; s <= 511; s++) begin
      if (s <= 255)      lv = s;
      else if (s <= 510) lv = 510 - s;
      else               lv = 1;
      step3(lv);
      if (s == 255) duty("duty_l255", 255);
    end

    for (int s = 2; s <= 100; s++) step3(s);
    tick(1'b0, 0);
    tick(1'b0, 0);
    @(negedge clk);
    tick_in = 1'b1;
    n = cyc;
    pulse_q.push_back(n + 3);
    repeat (3) @(negedge clk);
    mode = 2'b01;
    push_lvl(255, n + 4);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);

    set_cfg(1'b1, 2'b10, 1'b1, 0);
    tick(1'b0, 0);
    tick(1'b0, 0);
    set_cfg(1'b1, 2'b11, 1'b0, 0);
    step3(255);
    step3(0);

    set_cfg(1'b1, 2'b10, 1'b0, 0);
    for (int s = 1; s <= 200; s++) step3(s);
    repeat (520) @(negedge clk);
    k   = 0;
    got = 1'b0;
    while (k < 600 && !got) begin
      @(posedge clk);
      #1;
      if (pwm_out === 1'b1) got = 1'b1;
      k++;
    end
    chk("pwm_high_seen", int'(got), 1);
    @(negedge clk);
    enable = 1'b0;
    push_lvl(0, cyc + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("en_low_pwm", int'(pwm_out), 0);
    duty("duty_disabled", 0);
    set_cfg(1'b1, 2'b10, 1'b0, 0);
    step3(1);

    @(negedge clk);
    RST  = 1'b1;
    mode = 2'b01;
    push_lvl(0, cyc + 1);
    @(posedge clk);
    #1;
    chk("midrst_pwm", int'(pwm_out), 0);
    @(negedge clk);
    RST = 1'b0;
    push_lvl(255, cyc + 1);
    duty("duty_steady", 255);

    @(negedge clk);
    tick_in = 1'b1;
    n = cyc;
    pulse_q.push_back(n + 3);
    repeat (1000) @(negedge clk);
    tick_in = 1'b0;
    repeat (1000) @(negedge clk);

    repeat (10) @(negedge clk);
    chk("pulse_q_empty", pulse_q.size(), 0);
    chk("level_q_empty", lvl_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
